// File: rtl/pico_irq_ctrl.sv
// Interrupt controller and I/O register block for the PicoBlaze core.
// Captures rising edges from the interrupt sources and runs the interrupt/interrupt_ack handshake.
module pico_irq_ctrl #(
    parameter int unsigned N_SRC   = 4,
    parameter logic [7:0]  BASE_ID = 8'h80
) (
    input  logic             clk,
    input  logic             cpu_reset_n,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [7:0]       port_id,
    input  logic             write_strobe,
    input  logic             read_strobe,
    input  logic [7:0]       out_port,
    output logic [7:0]       in_port_o,
    output logic             in_sel,
    output logic             interrupt,
    input  logic             interrupt_ack
);

    typedef enum logic [1:0] {StIdle, StAssert, StService} state_e;

    state_e           state_q, state_d;
    logic [N_SRC-1:0] irq_src_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [7:0]       vector_q, vector_d;
    logic [7:0]       in_port_d;

    logic             hit;
    logic [1:0]       offset;
    logic             wr_pend, wr_mask, wr_eoi;
    logic [N_SRC-1:0] qual;
    logic [N_SRC-1:0] win_oh;
    logic [2:0]       win_idx;
    logic             ack_take;
    logic [N_SRC-1:0] pend_clr;
    logic [7:0]       rd_data;

    // read_strobe is not needed: the read mux is refreshed every cycle.
    logic unused_in;
    assign unused_in = ^{read_strobe, out_port, vector_q[7:3]};

    assign hit     = (port_id[7:2] == BASE_ID[7:2]);
    assign offset  = port_id[1:0];
    assign wr_pend = write_strobe && hit && (offset == 2'd0);
    assign wr_mask = write_strobe && hit && (offset == 2'd1);
    assign wr_eoi  = write_strobe && hit && (offset == 2'd3);
    assign qual    = pending_q & mask_q;

    assign interrupt = (state_q == StAssert);

    // Fixed priority: scanning downwards leaves the lowest set index as winner.
    always_comb begin
        win_idx = 3'd0;
        win_oh  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (qual[i]) begin
                win_idx   = 3'(i);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ack_take = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|qual) state_d = StAssert;
            end
            StAssert: begin
                if (interrupt_ack) begin
                    ack_take = 1'b1;
                    state_d  = StService;
                end else if (qual == '0) begin
                    state_d = StIdle;
                end
            end
            StService: begin
                if (wr_eoi) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // A new edge on the same cycle as a clear keeps the bit set.
    always_comb begin
        pend_clr = '0;
        if (wr_pend)  pend_clr = pend_clr | out_port[N_SRC-1:0];
        if (ack_take) pend_clr = pend_clr | win_oh;
        pending_d = (pending_q & ~pend_clr) | (irq_src & ~irq_src_q);
        mask_d    = wr_mask ? out_port[N_SRC-1:0] : mask_q;
        vector_d  = vector_q;
        if (ack_take) vector_d = (|qual) ? {5'b0, win_idx} : 8'hFF;
    end

    always_comb begin
        rd_data = 8'h00;
        unique case (offset)
            2'd0: rd_data = 8'(pending_q);
            2'd1: rd_data = 8'(mask_q);
            2'd2: rd_data = (state_q == StService) ? {1'b1, 4'b0, vector_q[2:0]} : 8'hFF;
            2'd3: rd_data = 8'h00;
            default: rd_data = 8'h00;
        endcase
        in_port_d = hit ? rd_data : 8'h00;
    end

    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            state_q   <= StIdle;
            irq_src_q <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            vector_q  <= 8'hFF;
            in_port_o <= 8'h00;
            in_sel    <= 1'b0;
        end else begin
            state_q   <= state_d;
            irq_src_q <= irq_src;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            vector_q  <= vector_d;
            in_port_o <= in_port_d;
            in_sel    <= hit;
        end
    end

endmodule

// File: tb/tb_pico_irq_ctrl.sv
// Scoreboard bench for pico_irq_ctrl: stimulus pushes expectations, a negedge monitor checks them.
module tb_pico_irq_ctrl;

    localparam logic [7:0] A_PEND = 8'h80;
    localparam logic [7:0] A_MASK = 8'h81;
    localparam logic [7:0] A_VEC  = 8'h82;
    localparam logic [7:0] A_EOI  = 8'h83;

    localparam int K_READ = 1;
    localparam int K_INT  = 2;
    localparam int K_RST  = 3;

    typedef struct {
        int         kind;
        string      name;
        logic [8:0] exp;
    } chk_t;

    logic       clk = 1'b0;
    logic       cpu_reset_n = 1'b0;
    logic [3:0] irq_src = '0;
    logic [7:0] port_id = '0;
    logic       write_strobe = 1'b0;
    logic       read_strobe = 1'b0;
    logic [7:0] out_port = '0;
    logic [7:0] in_port_o;
    logic       in_sel;
    logic       interrupt;
    logic       interrupt_ack = 1'b0;

    chk_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   probe = 0;
    logic rd_q = 1'b0;

    pico_irq_ctrl #(.N_SRC(4), .BASE_ID(8'h80)) dut (
        .clk          (clk),
        .cpu_reset_n  (cpu_reset_n),
        .irq_src      (irq_src),
        .port_id      (port_id),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .out_port     (out_port),
        .in_port_o    (in_port_o),
        .in_sel       (in_sel),
        .interrupt    (interrupt),
        .interrupt_ack(interrupt_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_q <= read_strobe;

    task automatic pop_cmp(input int kind, input logic [8:0] got);
        chk_t c;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL monitor: output seen with empty scoreboard, got %h", got);
        end else begin
            c = sb.pop_front();
            if (c.kind != kind) begin
                n_fail++;
                $display("FAIL %s: kind got %0d expected %0d", c.name, kind, c.kind);
            end else if (got !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", c.name, got, c.exp);
            end
        end
    endtask

    // Monitor: a read result is due the cycle after read_strobe; probes ask for a spot check.
    always @(negedge clk) begin
        if (rd_q) pop_cmp(K_READ, {in_sel, in_port_o});
        if (probe == K_INT) pop_cmp(K_INT, {8'h00, interrupt});
        if (probe == K_RST) pop_cmp(K_RST, {interrupt | in_sel, in_port_o});
    end

    task automatic push(input int kind, input string name, input logic [8:0] exp);
        chk_t c;
        c.kind = kind;
        c.name = name;
        c.exp  = exp;
        sb.push_back(c);
    endtask

    task automatic rd(input logic [7:0] addr, input logic [8:0] exp, input string name);
        @(posedge clk); #1;
        port_id     = addr;
        read_strobe = 1'b1;
        push(K_READ, name, exp);
        @(posedge clk); #1;
        read_strobe = 1'b0;
        port_id     = 8'h00;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        @(posedge clk); #1;
        port_id      = addr;
        out_port     = data;
        write_strobe = 1'b1;
        @(posedge clk); #1;
        write_strobe = 1'b0;
        port_id      = 8'h00;
    endtask

    task automatic pulse_src(input logic [3:0] bits);
        @(posedge clk); #1;
        irq_src = bits;
        @(posedge clk); #1;
        irq_src = '0;
    endtask

    task automatic ack();
        @(posedge clk); #1;
        interrupt_ack = 1'b1;
        @(posedge clk); #1;
        interrupt_ack = 1'b0;
    endtask

    task automatic check_int(input logic exp, input string name);
        push(K_INT, name, {8'h00, exp});
        probe = K_INT;
        @(negedge clk); #1;
        probe = 0;
    endtask

    task automatic check_rst(input string name);
        push(K_RST, name, 9'h000);
        probe = K_RST;
        @(negedge clk); #1;
        probe = 0;
    endtask

    task automatic wait_int(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (interrupt === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: interrupt got 0 expected 1 within 12 cycles", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        check_rst("reset_outputs");
        @(posedge clk); #1;
        cpu_reset_n = 1'b1;
        rd(A_PEND, 9'h100, "reset_pend");
        rd(A_VEC, 9'h1FF, "reset_vec");

        // 1: single source, two-cycle latency, vector read-back
        wr(A_MASK, 8'h0F);
        rd(A_MASK, 9'h10F, "mask_rb");
        pulse_src(4'b0100);
        check_int(1'b0, "t1_latency_n1");
        check_int(1'b1, "t1_latency_n2");
        ack();
        check_int(1'b0, "t1_int_drop");
        rd(A_VEC, 9'h182, "t1_vec");
        rd(A_PEND, 9'h100, "t1_pend");
        rd(A_EOI, 9'h100, "eoi_read");
        rd(8'h84, 9'h000, "unmapped");
        wr(A_EOI, 8'h00);

        // 2: simultaneous edges, priority, re-assert after EOI
        pulse_src(4'b1010);
        wait_int("t2_int_a");
        ack();
        rd(A_VEC, 9'h181, "t2_vec1");
        check_int(1'b0, "t2_service_quiet");
        rd(A_PEND, 9'h108, "t2_pend3");
        wr(A_EOI, 8'h5A);
        wait_int("t2_int_b");
        ack();
        rd(A_VEC, 9'h183, "t2_vec3");
        rd(A_PEND, 9'h100, "t2_pend0");
        wr(A_EOI, 8'h00);

        // 3: masked source pends but does not interrupt
        wr(A_MASK, 8'h00);
        pulse_src(4'b0001);
        check_int(1'b0, "t3_masked_a");
        check_int(1'b0, "t3_masked_b");
        rd(A_PEND, 9'h101, "t3_pend");
        wr(A_MASK, 8'h01);
        wait_int("t3_unmask");

        // 4: W1C in ASSERT drops the request back to idle
        wr(A_PEND, 8'hFF);
        rd(A_VEC, 9'h1FF, "t4_vec_idle");
        check_int(1'b0, "t4_int_fall");
        rd(A_PEND, 9'h100, "t4_pend");

        // 5: edge and W1C on the same bit in the same cycle
        wr(A_MASK, 8'h00);
        @(posedge clk); #1;
        irq_src      = 4'b0100;
        port_id      = A_PEND;
        out_port     = 8'h04;
        write_strobe = 1'b1;
        @(posedge clk); #1;
        irq_src      = '0;
        write_strobe = 1'b0;
        port_id      = 8'h00;
        rd(A_PEND, 9'h104, "t5_set_wins");
        wr(A_PEND, 8'h04);
        rd(A_PEND, 9'h100, "t5_w1c");

        // 6: reset during SERVICE
        wr(A_MASK, 8'h04);
        pulse_src(4'b0100);
        wait_int("t6_int");
        ack();
        rd(A_VEC, 9'h182, "t6_in_service");
        @(posedge clk); #1;
        cpu_reset_n = 1'b0;
        check_rst("t6_reset_outputs");
        @(posedge clk); #1;
        cpu_reset_n = 1'b1;
        rd(A_PEND, 9'h100, "t6_pend");
        rd(A_MASK, 9'h100, "t6_mask");
        rd(A_VEC, 9'h1FF, "t6_vec");
        check_int(1'b0, "t6_int");

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
